// File: rtl/fifo_pwm_audio.sv
// PWM audio output stage fed from a sample FIFO, with one-word prefetch and underrun fill.
// Optional build macro AUD_VOLUME_EN adds a 3-bit vol input that scales each sample toward midscale.
module fifo_pwm_audio #(
  parameter int SAMPLE_WIDTH     = 8,
  parameter int SAMPLES_PER_WORD = 4,
  parameter int FIFO_DATA_WIDTH  = SAMPLE_WIDTH * SAMPLES_PER_WORD,
  parameter int SIGNED_IN        = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       aud_en,
  input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                       fifo_empty,
  output logic                       fifo_rd_en,
  output logic                       aud_pwm,
  output logic                       aud_sd,
  output logic                       underrun,
  input  logic                       underrun_clr,
  output logic                       sample_tick
`ifdef AUD_VOLUME_EN
  ,
  input  logic [2:0]                 vol
`endif
);

  localparam int W     = SAMPLE_WIDTH;
  localparam int SPW   = SAMPLES_PER_WORD;
  localparam int FDW   = FIFO_DATA_WIDTH;
  localparam int IDX_W = (SPW > 1) ? $clog2(SPW) : 1;

  localparam logic [W-1:0]     MID      = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]     CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0]     CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0]     CNT_ONE  = W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPW - 1);
  localparam logic [FDW-1:0]   MID_WORD = FDW'({SPW{MID}});

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_pwm_cnt;
  logic [W-1:0]     r_duty;
  logic [FDW-1:0]   r_cur_word;
  logic [FDW-1:0]   r_buf;
  logic             r_buf_valid;
  logic             r_rd_dly;
  logic [IDX_W-1:0] r_sample_idx;

  logic [2:0]       w_vol;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [W-1:0]     w_next_sample;
  logic             w_boundary;
  logic             w_bypass;

  // Offset-binary conversion and optional attenuation about midscale.
  function automatic logic [W-1:0] f_duty(input logic [W-1:0] smp, input logic [2:0] shamt);
    logic [W-1:0]   ob;
    logic signed [W:0] diff;
    ob   = (SIGNED_IN != 0) ? (smp ^ MID) : smp;
    diff = $signed({1'b0, ob}) - $signed({1'b0, MID});
    diff = diff >>> shamt;
    return MID + diff[W-1:0];
  endfunction

`ifdef AUD_VOLUME_EN
  assign w_vol = vol;
`else
  assign w_vol = 3'd0;
`endif

  assign w_boundary = (r_state == RUN) && (r_pwm_cnt == CNT_MAX);
  // A read landing on the word boundary goes straight into the current word.
  assign w_bypass   = w_boundary && (r_sample_idx == IDX_LAST) && !r_buf_valid && r_rd_dly;

  // Select the sample that follows the current one within the playing word.
  always_comb begin
    w_idx_nxt     = r_sample_idx + IDX_ONE;
    w_next_sample = MID;
    for (int i = 0; i < SPW; i++) begin
      w_next_sample = (w_idx_nxt == IDX_W'(i)) ? r_cur_word[i*W +: W] : w_next_sample;
    end
  end

  // Playback state machine, prefetch handshake and PWM generation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pwm_cnt    <= CNT_ZERO;
      r_duty       <= MID;
      r_cur_word   <= MID_WORD;
      r_buf        <= {FDW{1'b0}};
      r_buf_valid  <= 1'b0;
      r_rd_dly     <= 1'b0;
      r_sample_idx <= IDX_LAST;
      fifo_rd_en   <= 1'b0;
      aud_pwm      <= 1'b0;
      aud_sd       <= 1'b0;
      underrun     <= 1'b0;
      sample_tick  <= 1'b0;
    end else begin
      fifo_rd_en  <= 1'b0;
      sample_tick <= 1'b0;
      if (underrun_clr) begin
        underrun <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          aud_pwm     <= 1'b0;
          aud_sd      <= 1'b0;
          r_buf_valid <= 1'b0;
          r_rd_dly    <= 1'b0;
          if (aud_en) begin
            r_state      <= RUN;
            aud_sd       <= 1'b1;
            r_pwm_cnt    <= CNT_ZERO;
            r_cur_word   <= MID_WORD;
            r_sample_idx <= IDX_LAST;
            r_duty       <= MID;
            underrun     <= 1'b0;
          end
        end
        RUN: begin
          if (!aud_en) begin
            r_state     <= IDLE;
            aud_pwm     <= 1'b0;
            aud_sd      <= 1'b0;
            r_buf_valid <= 1'b0;
            r_rd_dly    <= 1'b0;
          end else begin
            aud_sd    <= 1'b1;
            aud_pwm   <= (r_pwm_cnt < r_duty);
            r_pwm_cnt <= r_pwm_cnt + CNT_ONE;
            r_rd_dly  <= fifo_rd_en;
            if (!r_buf_valid && !fifo_rd_en && !r_rd_dly && !fifo_empty) begin
              fifo_rd_en <= 1'b1;
            end
            if (w_boundary) begin
              sample_tick <= 1'b1;
              if (r_sample_idx < IDX_LAST) begin
                r_sample_idx <= w_idx_nxt;
                r_duty       <= f_duty(w_next_sample, w_vol);
              end else if (r_buf_valid) begin
                r_cur_word   <= r_buf;
                r_buf_valid  <= 1'b0;
                r_sample_idx <= IDX_ZERO;
                r_duty       <= f_duty(r_buf[W-1:0], w_vol);
              end else if (r_rd_dly) begin
                r_cur_word   <= fifo_rd_data;
                r_sample_idx <= IDX_ZERO;
                r_duty       <= f_duty(fifo_rd_data[W-1:0], w_vol);
              end else begin
                r_cur_word   <= MID_WORD;
                r_sample_idx <= IDX_LAST;
                r_duty       <= MID;
                underrun     <= 1'b1;
              end
            end
            if (r_rd_dly && !w_bypass) begin
              r_buf       <= fifo_rd_data;
              r_buf_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= IDLE;
          aud_pwm     <= 1'b0;
          aud_sd      <= 1'b0;
          r_buf_valid <= 1'b0;
          r_rd_dly    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_pwm_audio.sv
// Directed bench for fifo_pwm_audio: FIFO model, per-period high-count scoreboard.
module tb_fifo_pwm_audio;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, aud_en, underrun_clr;
  logic [31:0] fifo_rd_data;
  logic        fifo_empty, fifo_rd_en, aud_pwm, aud_sd, underrun, sample_tick;

  logic        aud_en2;
  logic [15:0] fifo2_rd_data;
  logic        fifo2_empty, rd2_en, aud2_pwm, aud2_sd, underrun2, tick2;

  fifo_pwm_audio #(.SAMPLE_WIDTH(8), .SAMPLES_PER_WORD(4), .FIFO_DATA_WIDTH(32), .SIGNED_IN(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .aud_en(aud_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .aud_pwm(aud_pwm), .aud_sd(aud_sd),
    .underrun(underrun), .underrun_clr(underrun_clr), .sample_tick(sample_tick)
`ifdef AUD_VOLUME_EN
    , .vol(3'd0)
`endif
  );

  fifo_pwm_audio #(.SAMPLE_WIDTH(8), .SAMPLES_PER_WORD(2), .FIFO_DATA_WIDTH(16), .SIGNED_IN(1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .aud_en(aud_en2), .fifo_rd_data(fifo2_rd_data),
    .fifo_empty(fifo2_empty), .fifo_rd_en(rd2_en), .aud_pwm(aud2_pwm), .aud_sd(aud2_sd),
    .underrun(underrun2), .underrun_clr(1'b0), .sample_tick(tick2)
`ifdef AUD_VOLUME_EN
    , .vol(3'd0)
`endif
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] q[$];
  logic [15:0] q2[$];
  int          exp_q[$];
  int          exp2_q[$];
  int          win_n = 0, hi_n = 0, hi2_n = 0;
  int          rd_cnt = 0, rd2_cnt = 0;
  bit          mon_on = 1'b0, mon2_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // One clock: serve FIFO reads, then accumulate/score PWM periods.
  task automatic cyc();
    int e;
    @(negedge clk);
    if (fifo_rd_en) begin
      chk("rd_while_nonempty", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        fifo_rd_data = q.pop_front();
        rd_cnt++;
      end
    end
    fifo_empty = (q.size() == 0);
    if (rd2_en) begin
      chk("sgn_rd_while_nonempty", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) begin
        fifo2_rd_data = q2.pop_front();
        rd2_cnt++;
      end
    end
    fifo2_empty = (q2.size() == 0);
    if (mon_on) begin
      win_n++;
      hi_n += aud_pwm ? 1 : 0;
      if (sample_tick) begin
        chk("tick_spacing", 32'(win_n), 32'd256);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF;
        chk("period_high", 32'(hi_n), 32'(e));
        win_n = 0;
        hi_n  = 0;
      end
    end
    if (mon2_on) begin
      hi2_n += aud2_pwm ? 1 : 0;
      if (tick2) begin
        e = (exp2_q.size() > 0) ? exp2_q.pop_front() : 32'hFFFF;
        chk("sgn_period_high", 32'(hi2_n), 32'(e));
        hi2_n = 0;
      end
    end
  endtask

  task automatic push_fifo(input logic [31:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic expect_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(int'(w[i*8 +: 8]));
  endtask

  task automatic enable1();
    aud_en = 1'b1;
    cyc();
    mon_on = 1'b1;
    win_n  = 0;
    hi_n   = 0;
    chk("entry_aud_sd", 32'(aud_sd), 32'd1);
  endtask

  // Run until only n_left periods remain; optionally pulse underrun_clr on the last boundary edge.
  task automatic run_until(input int n_left, input bit clr_last);
    int budget = 0;
    while (exp_q.size() > n_left && budget < 5000) begin
      underrun_clr = clr_last && (exp_q.size() == n_left + 1) && (win_n == 255);
      cyc();
      budget++;
    end
    underrun_clr = 1'b0;
    chk("run_budget", 32'(exp_q.size()), 32'(n_left));
  endtask

  initial begin
    int budget;
    rst_n = 1'b0; aud_en = 1'b0; aud_en2 = 1'b0; underrun_clr = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = 32'd0; fifo2_empty = 1'b1; fifo2_rd_data = 16'd0;
    repeat (3) cyc();
    chk("reset_outputs", 32'({aud_pwm, aud_sd, fifo_rd_en, underrun, sample_tick}), 32'd0);
    chk("reset_outputs_sgn", 32'({aud2_pwm, aud2_sd, rd2_en, underrun2, tick2}), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Single word then underrun.
    exp_q.push_back(128);
    push_fifo(32'h40C0FF00);
    expect_word(32'h40C0FF00);
    exp_q.push_back(128);
    exp_q.push_back(128);
    enable1();
    run_until(0, 1'b0);
    chk("s1_rd_count", 32'(rd_cnt), 32'd1);
    chk("s1_underrun", 32'(underrun), 32'd1);
    underrun_clr = 1'b1;
    cyc();
    underrun_clr = 1'b0;
    chk("underrun_clr", 32'(underrun), 32'd0);

    // Three words back to back, resuming from underrun fill.
    exp_q.push_back(128);
    push_fifo(32'h807F10EF); expect_word(32'h807F10EF);
    push_fifo(32'h20406080); expect_word(32'h20406080);
    push_fifo(32'hFE01AA55); expect_word(32'hFE01AA55);
    run_until(1, 1'b0);
    chk("s2_no_underrun", 32'(underrun), 32'd0);
    chk("s2_rd_count", 32'(rd_cnt), 32'd4);
    run_until(0, 1'b1);
    chk("s2_set_wins_over_clr", 32'(underrun), 32'd1);
    cyc();
    chk("s2_underrun_sticky", 32'(underrun), 32'd1);

    // Drop enable right after a read is issued.
    push_fifo(32'h11223344);
    cyc();
    chk("s3_read_issued", 32'(rd_cnt), 32'd5);
    aud_en = 1'b0;
    mon_on = 1'b0;
    cyc();
    chk("s3_drop_outputs", 32'({aud_pwm, aud_sd, fifo_rd_en}), 32'd0);
    push_fifo(32'h10305070);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s3_idle_no_read", 32'(fifo_rd_en), 32'd0);
    end
    exp_q.push_back(128);
    expect_word(32'h10305070);
    exp_q.push_back(128);
    enable1();
    chk("s3_entry_clears_underrun", 32'(underrun), 32'd0);
    run_until(0, 1'b0);
    chk("s3_rd_count", 32'(rd_cnt), 32'd6);

    // Reset during RUN.
    mon_on = 1'b0;
    rst_n  = 1'b0;
    aud_en = 1'b0;
    cyc();
    chk("s4_reset_outputs", 32'({aud_pwm, aud_sd, fifo_rd_en, underrun, sample_tick}), 32'd0);
    rst_n = 1'b1;
    push_fifo(32'hF00FC33C);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("s4_no_read_before_en", 32'(fifo_rd_en), 32'd0);
    end
    exp_q.push_back(128);
    expect_word(32'hF00FC33C);
    exp_q.push_back(128);
    enable1();
    run_until(0, 1'b0);
    chk("s4_rd_count", 32'(rd_cnt), 32'd7);
    aud_en = 1'b0;
    mon_on = 1'b0;
    cyc();

    // Two's-complement input instance, two samples per word.
    q2.push_back(16'h7F80);
    q2.push_back(16'hC000);
    fifo2_empty = 1'b0;
    exp2_q.push_back(128);
    exp2_q.push_back(0);
    exp2_q.push_back(255);
    exp2_q.push_back(128);
    exp2_q.push_back(64);
    exp2_q.push_back(128);
    aud_en2 = 1'b1;
    cyc();
    mon2_on = 1'b1;
    hi2_n   = 0;
    budget  = 0;
    while (exp2_q.size() > 0 && budget < 3000) begin
      cyc();
      budget++;
    end
    chk("sgn_run_budget", 32'(exp2_q.size()), 32'd0);
    chk("sgn_rd_count", 32'(rd2_cnt), 32'd2);
    chk("sgn_underrun", 32'(underrun2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
